// File: rtl/search_if.sv
// search_if: controller <-> frequency-search datapath handshake bundle.
interface search_if;
  logic start;
  logic equal;
  logic over;
  logic dp_clr;
  logic load;
  logic running;
  logic incFreq;
  logic busy;
  logic done;
  logic timeout;
  modport master (
    input  start, equal, over,
    output dp_clr, load, running, incFreq, busy, done, timeout
  );
  modport slave (
    output start, equal, over,
    input  dp_clr, load, running, incFreq, busy, done, timeout
  );
endinterface

// File: rtl/search_controller.sv
// search_controller: sequences one frequency search per start pulse (clear, load, scan, drain, done)
// and aligns the equal flag with the datapath pipeline so each address is counted exactly once.
module search_controller #(
  parameter int ADDR_W   = 9,
  parameter int LAT      = 3,
  parameter int WD_EXTRA = 16
) (
  input logic clk,
  input logic reset,
  search_if.master bus
);
  localparam int LIMIT = (1 << ADDR_W) + LAT + WD_EXTRA;
  localparam int WD_W  = $clog2(LIMIT + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SCAN, DRAIN, DONE} state_t;
  state_t state;
  logic [LAT-1:0] valid;
  logic [WD_W-1:0] wd;
  logic [2:0] dcnt;
  logic to_r;
  logic armed;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      valid <= '0;
      wd    <= '0;
      dcnt  <= '0;
      to_r  <= 1'b0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE:  if (bus.start && armed) state <= CLEAR;
        CLEAR: state <= LOAD;
        LOAD: begin
          state <= SCAN;
          wd    <= '0;
          valid <= '0;
        end
        // valid tracks which in-flight compares belong to issued addresses
        SCAN: begin
          valid <= LAT'({valid, 1'b1});
          wd    <= wd + 1'b1;
          if (bus.over) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else if (wd == WD_W'(LIMIT - 1)) begin
            state <= DONE;
            to_r  <= 1'b1;
          end
        end
        DRAIN: begin
          valid <= LAT'({valid, 1'b0});
          dcnt  <= dcnt + 1'b1;
          if (dcnt == 3'(LAT - 1)) state <= DONE;
        end
        DONE: if (bus.start) begin
          state <= CLEAR;
          to_r  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.dp_clr  = state == CLEAR;
  assign bus.load    = state == LOAD;
  assign bus.running = state == SCAN;
  assign bus.busy    = state inside {CLEAR, LOAD, SCAN, DRAIN};
  assign bus.done    = state == DONE;
  assign bus.timeout = to_r;
  assign bus.incFreq = (state inside {SCAN, DRAIN}) && bus.equal && valid[LAT-1];
endmodule
